// File: rtl/sample_pkg.sv
// Shared types, parameters and fixed-point helpers for the uniform point sampler.
// Fixed-point format: signed TOTAL_BITS, FRAC_BITS fractional bits, all arithmetic wraps.
package sample_pkg;

  localparam int unsigned N_SAMPLES  = 32;
  localparam int unsigned LOG2_N     = 5;
  localparam int unsigned INT_BITS   = 12;
  localparam int unsigned FRAC_BITS  = 4;
  localparam int unsigned TOTAL_BITS = INT_BITS + FRAC_BITS;

  typedef logic signed [TOTAL_BITS-1:0] fix_t;
  typedef logic [LOG2_N-1:0]            idx_t;

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_e;

  // Uniform z step: (far - near) with one guard bit, floor-divided by N_SAMPLES.
  function automatic fix_t step_calc(input fix_t near_v, input fix_t far_v);
    logic signed [TOTAL_BITS:0] diff;
    logic signed [TOTAL_BITS:0] shifted;
    diff    = {far_v[TOTAL_BITS-1], far_v} - {near_v[TOTAL_BITS-1], near_v};
    shifted = diff >>> LOG2_N;
    return shifted[TOTAL_BITS-1:0];
  endfunction

  // Full-width signed product, rescaled by FRAC_BITS, low bits kept (wraps).
  function automatic fix_t fix_mul(input fix_t a, input fix_t b);
    logic signed [2*TOTAL_BITS-1:0] a_w;
    logic signed [2*TOTAL_BITS-1:0] b_w;
    logic signed [2*TOTAL_BITS-1:0] prod;
    a_w  = a;
    b_w  = b;
    prod = a_w * b_w;
    prod = prod >>> FRAC_BITS;
    return prod[TOTAL_BITS-1:0];
  endfunction

  function automatic fix_t fix_add(input fix_t a, input fix_t b);
    fix_t sum;
    sum = a + b;
    return sum;
  endfunction

endpackage

// File: rtl/sample_pt_lane.sv
// One axis of the shared point datapath: pt_o = o_i + ((d_i * z_i) >>> FRAC_BITS).
// Ports:
//   o_i  - ray origin component
//   d_i  - ray direction component
//   z_i  - sample depth
//   pt_o - sampled point component (combinational, wrapping)
module sample_pt_lane
  import sample_pkg::*;
(
  input  fix_t o_i,
  input  fix_t d_i,
  input  fix_t z_i,
  output fix_t pt_o
);

  assign pt_o = fix_add(o_i, fix_mul(d_i, z_i));

endmodule

// File: rtl/sample_points_seq.sv
// Per-ray uniform point sampler. Accepts one ray, computes the z step, then streams
// N_SAMPLES points o + d*z over a valid/ready interface using one shared 3-lane datapath.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   ray_valid/ray_ready        - ray handshake (ready only when idle)
//   ray_o_*/ray_d_*/near/far   - ray origin, direction, depth bounds
//   pt_valid/pt_ready          - point handshake
//   pt_x/y/z, pt_zval, pt_idx  - registered sample point, depth and index
//   pt_last                    - marks the final sample of the ray
//   busy                       - a ray is in flight
module sample_points_seq
  import sample_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ray_valid,
  output logic ray_ready,
  input  fix_t ray_o_x,
  input  fix_t ray_o_y,
  input  fix_t ray_o_z,
  input  fix_t ray_d_x,
  input  fix_t ray_d_y,
  input  fix_t ray_d_z,
  input  fix_t near,
  input  fix_t far,
  output logic pt_valid,
  input  logic pt_ready,
  output fix_t pt_x,
  output fix_t pt_y,
  output fix_t pt_z,
  output fix_t pt_zval,
  output idx_t pt_idx,
  output logic pt_last,
  output logic busy
);

  state_e state_q;
  fix_t   o_x_q, o_y_q, o_z_q;
  fix_t   d_x_q, d_y_q, d_z_q;
  fix_t   near_q, far_q, step_q;
  fix_t   pt_x_q, pt_y_q, pt_z_q, pt_zval_q;
  idx_t   pt_idx_q;
  logic   pt_valid_q, pt_last_q;

  fix_t zval_d;
  fix_t lane_x, lane_y, lane_z;

  // The point register doubles as the z accumulator: in SETUP the datapath sees near,
  // in RUN it sees the next z so the following point is ready at the handshake edge.
  assign zval_d = (state_q == SETUP) ? near_q : fix_add(pt_zval_q, step_q);

  sample_pt_lane u_lane_x (.o_i(o_x_q), .d_i(d_x_q), .z_i(zval_d), .pt_o(lane_x));
  sample_pt_lane u_lane_y (.o_i(o_y_q), .d_i(d_y_q), .z_i(zval_d), .pt_o(lane_y));
  sample_pt_lane u_lane_z (.o_i(o_z_q), .d_i(d_z_q), .z_i(zval_d), .pt_o(lane_z));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      o_x_q      <= '0;
      o_y_q      <= '0;
      o_z_q      <= '0;
      d_x_q      <= '0;
      d_y_q      <= '0;
      d_z_q      <= '0;
      near_q     <= '0;
      far_q      <= '0;
      step_q     <= '0;
      pt_x_q     <= '0;
      pt_y_q     <= '0;
      pt_z_q     <= '0;
      pt_zval_q  <= '0;
      pt_idx_q   <= '0;
      pt_valid_q <= 1'b0;
      pt_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ray_valid) begin
            o_x_q   <= ray_o_x;
            o_y_q   <= ray_o_y;
            o_z_q   <= ray_o_z;
            d_x_q   <= ray_d_x;
            d_y_q   <= ray_d_y;
            d_z_q   <= ray_d_z;
            near_q  <= near;
            far_q   <= far;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          step_q     <= step_calc(near_q, far_q);
          pt_x_q     <= lane_x;
          pt_y_q     <= lane_y;
          pt_z_q     <= lane_z;
          pt_zval_q  <= zval_d;
          pt_idx_q   <= '0;
          pt_last_q  <= 1'b0;
          pt_valid_q <= 1'b1;
          state_q    <= RUN;
        end
        RUN: begin
          if (pt_ready) begin
            if (pt_last_q) begin
              pt_valid_q <= 1'b0;
              pt_last_q  <= 1'b0;
              state_q    <= IDLE;
            end else begin
              pt_x_q    <= lane_x;
              pt_y_q    <= lane_y;
              pt_z_q    <= lane_z;
              pt_zval_q <= zval_d;
              pt_idx_q  <= pt_idx_q + idx_t'(1);
              pt_last_q <= (pt_idx_q == idx_t'(N_SAMPLES - 2));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ray_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pt_valid  = pt_valid_q;
  assign pt_last   = pt_last_q;
  assign pt_x      = pt_x_q;
  assign pt_y      = pt_y_q;
  assign pt_z      = pt_z_q;
  assign pt_zval   = pt_zval_q;
  assign pt_idx    = pt_idx_q;

endmodule

// File: tb/tb_sample_points_seq.sv
// Scoreboard bench for sample_points_seq: each accepted ray pushes its expected
// points, each point handshake pops and compares one entry.
module tb_sample_points_seq;
  import sample_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ray_valid = 1'b0;
  logic ray_ready;
  fix_t ray_o_x = '0, ray_o_y = '0, ray_o_z = '0;
  fix_t ray_d_x = '0, ray_d_y = '0, ray_d_z = '0;
  fix_t near = '0, far = '0;
  logic pt_valid;
  logic pt_ready = 1'b0;
  fix_t pt_x, pt_y, pt_z, pt_zval;
  idx_t pt_idx;
  logic pt_last;
  logic busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    fix_t x;
    fix_t y;
    fix_t z;
    fix_t zval;
    int   idx;
    logic last;
  } pt_s;

  pt_s sb_q[$];

  always #5 clk = ~clk;

  sample_points_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ray_valid(ray_valid),
    .ray_ready(ray_ready),
    .ray_o_x  (ray_o_x),
    .ray_o_y  (ray_o_y),
    .ray_o_z  (ray_o_z),
    .ray_d_x  (ray_d_x),
    .ray_d_y  (ray_d_y),
    .ray_d_z  (ray_d_z),
    .near     (near),
    .far      (far),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .pt_x     (pt_x),
    .pt_y     (pt_y),
    .pt_z     (pt_z),
    .pt_zval  (pt_zval),
    .pt_idx   (pt_idx),
    .pt_last  (pt_last),
    .busy     (busy)
  );

  // Reference model, written with plain integer arithmetic.
  function automatic int mdl_step(input int nr, input int fr);
    int diff;
    diff = fr - nr;
    if (diff >= 0) return diff / 32;
    return -((-diff + 31) / 32);
  endfunction

  function automatic fix_t mdl_lane(input int o, input int d, input int z);
    int p;
    p = (d * z) >>> 4;
    return fix_t'(o + p);
  endfunction

  task automatic push_ray(input fix_t ox, input fix_t oy, input fix_t oz, input fix_t dx,
                          input fix_t dy, input fix_t dz, input fix_t nr, input fix_t fr);
    int   st;
    fix_t z;
    pt_s  e;
    st = mdl_step(int'(nr), int'(fr));
    for (int i = 0; i < 32; i++) begin
      z      = fix_t'(int'(nr) + i * st);
      e.x    = mdl_lane(int'(ox), int'(dx), int'(z));
      e.y    = mdl_lane(int'(oy), int'(dy), int'(z));
      e.z    = mdl_lane(int'(oz), int'(dz), int'(z));
      e.zval = z;
      e.idx  = i;
      e.last = (i == 31);
      sb_q.push_back(e);
    end
  endtask

  // Called at posedge+1 with the block idle; returns at posedge+1 in SETUP.
  task automatic send_ray(input fix_t ox, input fix_t oy, input fix_t oz, input fix_t dx,
                          input fix_t dy, input fix_t dz, input fix_t nr, input fix_t fr);
    ray_o_x = ox; ray_o_y = oy; ray_o_z = oz;
    ray_d_x = dx; ray_d_y = dy; ray_d_z = dz;
    near = nr; far = fr;
    ray_valid = 1'b1;
    checks++;
    if (ray_ready !== 1'b1) begin
      errors++;
      $display("FAIL ray_ready_idle: got %b want 1", ray_ready);
    end
    push_ray(ox, oy, oz, dx, dy, dz, nr, fr);
    @(posedge clk); #1;
    ray_valid = 1'b0;
    checks++;
    if ({pt_valid, busy, ray_ready} !== 3'b010) begin
      errors++;
      $display("FAIL setup_state: valid/busy/ready got %b%b%b want 010", pt_valid, busy,
               ray_ready);
    end
  endtask

  // mode 0: ready always high; 1: stall 3 cycles at stall_idx; 2: random ready.
  task automatic drain(input int mode, input int stall_idx, output int span,
                       output fix_t last_zval);
    int  cyc = 0;
    int  first = -1;
    int  last_cyc = 0;
    int  stall = 0;
    bit  done = 0;
    pt_s e;
    last_zval = '0;
    while (!done && cyc < 2000) begin
      if (mode == 1 && pt_valid && int'(pt_idx) == stall_idx && stall < 3) begin
        pt_ready = 1'b0;
        stall++;
        e = sb_q[0];
        checks++;
        if ({pt_x, pt_y, pt_z, pt_zval} !== {e.x, e.y, e.z, e.zval} || int'(pt_idx) != e.idx)
        begin
          errors++;
          $display("FAIL held_point: got idx=%0d (%0d,%0d,%0d) z=%0d want idx=%0d (%0d,%0d,%0d) z=%0d",
                   pt_idx, pt_x, pt_y, pt_z, pt_zval, e.idx, e.x, e.y, e.z, e.zval);
        end
      end else if (mode == 2) begin
        pt_ready = 1'($urandom_range(0, 1));
      end else begin
        pt_ready = 1'b1;
      end
      if (pt_valid && pt_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL extra_point: got idx=%0d want none", pt_idx);
        end else begin
          e = sb_q.pop_front();
          if ({pt_x, pt_y, pt_z, pt_zval} !== {e.x, e.y, e.z, e.zval} ||
              int'(pt_idx) != e.idx || pt_last !== e.last) begin
            errors++;
            $display("FAIL point: got idx=%0d (%0d,%0d,%0d) z=%0d last=%b want idx=%0d (%0d,%0d,%0d) z=%0d last=%b",
                     pt_idx, pt_x, pt_y, pt_z, pt_zval, pt_last,
                     e.idx, e.x, e.y, e.z, e.zval, e.last);
          end
          if (first < 0) first = cyc;
          last_cyc  = cyc;
          last_zval = pt_zval;
          if (sb_q.size() == 0) done = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    pt_ready = 1'b0;
    span = last_cyc - first;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d points pending want 0", sb_q.size());
      sb_q.delete();
    end else if ({ray_ready, pt_valid, pt_last, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL ray_end: ready/valid/last/busy got %b%b%b%b want 1000",
               ray_ready, pt_valid, pt_last, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pt_valid, pt_last, busy, ray_ready} !== 4'b0001 ||
        {pt_x, pt_y, pt_z, pt_zval} !== 64'd0 || pt_idx !== '0) begin
      errors++;
      $display("FAIL reset_state: valid/last/busy/ready=%b%b%b%b pt=(%0d,%0d,%0d) z=%0d idx=%0d want 0001 all zero",
               pt_valid, pt_last, busy, ray_ready, pt_x, pt_y, pt_z, pt_zval, pt_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sweep();
    int   span;
    fix_t lz;
    send_ray(16'sd16, 16'sd0, 16'sd0, 16'sd0, 16'sd16, 16'sd0, 16'sd32, 16'sd96);
    checks++;
    if (pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_setup: pt_valid got %b want 0", pt_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (pt_valid !== 1'b1 || pt_idx !== '0 || pt_zval !== 16'sd32) begin
      errors++;
      $display("FAIL first_point: valid=%b idx=%0d z=%0d want 1 0 32", pt_valid, pt_idx, pt_zval);
    end
    drain(0, 0, span, lz);
    checks++;
    if (span != 31 || lz !== 16'sd94) begin
      errors++;
      $display("FAIL sweep_span: got span=%0d lastz=%0d want 31 94", span, lz);
    end
  endtask

  task automatic test_backpressure();
    int   span;
    fix_t lz;
    send_ray(16'sd16, 16'sd0, 16'sd0, 16'sd0, 16'sd16, 16'sd0, 16'sd32, 16'sd96);
    drain(1, 5, span, lz);
    checks++;
    if (span != 34) begin
      errors++;
      $display("FAIL backpressure_span: got %0d want 34", span);
    end
  endtask

  task automatic test_neg_span();
    int   span;
    fix_t lz;
    send_ray(16'sd0, 16'sd0, 16'sd0, 16'sd16, 16'sd0, 16'sd0, 16'sd96, 16'sd26);
    drain(0, 0, span, lz);
    checks++;
    if (lz !== 16'sd3) begin
      errors++;
      $display("FAIL neg_last_z: got %0d want 3", lz);
    end
  endtask

  task automatic test_degenerate();
    int   span;
    fix_t lz;
    send_ray(16'sd5, -16'sd7, 16'sd9, 16'sd16, 16'sd16, -16'sd16, 16'sd48, 16'sd48);
    @(posedge clk); #1;
    checks++;
    if ({pt_x, pt_y, pt_z} !== {16'sd53, 16'sd41, -16'sd39}) begin
      errors++;
      $display("FAIL degenerate_pt: got (%0d,%0d,%0d) want (53,41,-39)", pt_x, pt_y, pt_z);
    end
    drain(2, 0, span, lz);
  endtask

  task automatic test_busy_reset();
    int   span;
    int   cyc = 0;
    int   exp_idx = 0;
    fix_t lz;
    pt_s  e;
    send_ray(16'sd0, 16'sd0, 16'sd0, 16'sd16, 16'sd16, 16'sd16, 16'sd16, 16'sd80);
    // A competing ray is offered throughout the run and must not be taken.
    ray_o_x = 16'sd100; near = 16'sd7; far = 16'sd9;
    ray_valid = 1'b1;
    pt_ready  = 1'b1;
    while (!(pt_valid && pt_idx == idx_t'(10)) && cyc < 100) begin
      checks++;
      if (ray_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_while_busy: got %b want 0", ray_ready);
      end
      if (pt_valid) begin
        e = sb_q.pop_front();
        checks++;
        if (int'(pt_idx) != exp_idx || pt_zval !== e.zval) begin
          errors++;
          $display("FAIL busy_point: got idx=%0d z=%0d want idx=%0d z=%0d",
                   pt_idx, pt_zval, exp_idx, e.zval);
        end
        exp_idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ray_valid = 1'b0;
    pt_ready  = 1'b0;
    rst_n     = 1'b0;
    #2;
    checks++;
    if ({pt_valid, ray_ready, busy} !== 3'b010 || pt_idx !== '0 || exp_idx != 10) begin
      errors++;
      $display("FAIL mid_reset: valid/ready/busy=%b%b%b idx=%0d seen=%0d want 010 0 10",
               pt_valid, ray_ready, busy, pt_idx, exp_idx);
    end
    sb_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_ray(16'sd1, 16'sd2, 16'sd3, -16'sd8, 16'sd24, 16'sd4, 16'sd20, 16'sd200);
    @(posedge clk); #1;
    checks++;
    if (pt_idx !== '0 || pt_zval !== 16'sd20) begin
      errors++;
      $display("FAIL restart_first: got idx=%0d z=%0d want 0 20", pt_idx, pt_zval);
    end
    drain(0, 0, span, lz);
  endtask

  task automatic test_wrap();
    int   span;
    fix_t lz;
    send_ray(16'sd32767, 16'sd0, 16'sd0, 16'sd16, 16'sd0, 16'sd0, 16'sd16, 16'sd16);
    @(posedge clk); #1;
    checks++;
    if (pt_x !== -16'sd32753) begin
      errors++;
      $display("FAIL wrap_x: got %0d want -32753", pt_x);
    end
    drain(0, 0, span, lz);
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_neg_span();
    test_degenerate();
    test_busy_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
